// File: rtl/print_mech_driver.sv
// Thermal print head driver: shifts one line of dots, latches, burns, steps paper motor two phases.
// Latency: line accepted in IDLE, SHIFT starts next cycle; line_done 2*CLK_DIV*HEAD_WIDTH+LATCH+BURN+2*STEP cycles later.
// Backpressure: line_ready only in IDLE; line_valid while busy is ignored.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   line_valid/line_ready      line handshake; line_data[HEAD_WIDTH-1] is the first dot shifted
//   line_done, busy            end-of-line pulse (first IDLE cycle), line-in-progress flag
//   mech_clk/data/latch/dst    head shift clock, serial data, latch strobe, burn strobe
//   mech_motor_phase_a/b       stepper phase outputs, sequence 00->01->11->10->00
module print_mech_driver #(
  parameter int HEAD_WIDTH   = 384,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 4,
  parameter int BURN_CYCLES  = 16,
  parameter int STEP_CYCLES  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_valid,
  input  logic [HEAD_WIDTH-1:0] line_data,
  output logic                  line_ready,
  output logic                  line_done,
  output logic                  busy,
  output logic                  mech_clk,
  output logic                  mech_data,
  output logic                  mech_latch,
  output logic                  mech_dst,
  output logic                  mech_motor_phase_a,
  output logic                  mech_motor_phase_b
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LATCH,
    BURN,
    STEP1,
    STEP2
  } state_t;

  // One shared cycle counter serves every timed state; size it for the longest one.
  localparam int SHIFT_MAX = 2 * CLK_DIV - 1;
  localparam int MAX_A     = (SHIFT_MAX > LATCH_CYCLES - 1) ? SHIFT_MAX : LATCH_CYCLES - 1;
  localparam int MAX_B     = (BURN_CYCLES > STEP_CYCLES) ? BURN_CYCLES - 1 : STEP_CYCLES - 1;
  localparam int CNT_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int DOT_W     = (HEAD_WIDTH > 1) ? $clog2(HEAD_WIDTH) : 1;

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_MAX);
  localparam logic [CNT_W-1:0] CLK_HIGH   = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BURN_LAST  = CNT_W'(BURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [DOT_W-1:0] DOT_LAST   = DOT_W'(HEAD_WIDTH - 1);

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [DOT_W-1:0]        dot, dot_n;
  logic [HEAD_WIDTH-1:0]   sreg, sreg_n;
  logic [1:0]              phase, phase_n;
  logic                    mech_clk_n, mech_data_n, line_done_n;

  assign mech_motor_phase_a = phase[1];
  assign mech_motor_phase_b = phase[0];

  // Next-state, counters and shift register.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dot_n   = dot;
    sreg_n  = sreg;
    case (state)
      IDLE: begin
        if (line_valid && line_ready) begin
          state_n = SHIFT;
          cnt_n   = '0;
          dot_n   = '0;
          sreg_n  = line_data;
        end
      end
      SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          // End of a dot: mech_clk falls here, so the next bit moves to the MSB.
          cnt_n  = '0;
          sreg_n = sreg << 1;
          if (dot == DOT_LAST) begin
            state_n = LATCH;
            dot_n   = '0;
          end else begin
            dot_n = dot + DOT_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          state_n = BURN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      BURN: begin
        if (cnt == BURN_LAST) begin
          state_n = STEP1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STEP1: begin
        if (cnt == STEP_LAST) begin
          state_n = STEP2;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STEP2: begin
        if (cnt == STEP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        dot_n   = '0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the coming state so
  // every output is a flop yet lines up with the state it belongs to.
  always_comb begin
    mech_clk_n  = (state_n == SHIFT) && (cnt_n >= CLK_HIGH);
    mech_data_n = (state_n == SHIFT) ? sreg_n[HEAD_WIDTH-1] : 1'b0;
    line_done_n = (state == STEP2) && (state_n == IDLE);
    phase_n     = phase;
    // Gray-style step {a,b} -> {b,~a} walks 00->01->11->10->00.
    if ((state_n == STEP1 && state != STEP1) || (state_n == STEP2 && state != STEP2)) begin
      phase_n = {phase[0], ~phase[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dot        <= '0;
      sreg       <= '0;
      phase      <= 2'b00;
      line_ready <= 1'b0;
      line_done  <= 1'b0;
      busy       <= 1'b0;
      mech_clk   <= 1'b0;
      mech_data  <= 1'b0;
      mech_latch <= 1'b0;
      mech_dst   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dot        <= dot_n;
      sreg       <= sreg_n;
      phase      <= phase_n;
      line_ready <= (state_n == IDLE);
      line_done  <= line_done_n;
      busy       <= (state_n != IDLE);
      mech_clk   <= mech_clk_n;
      mech_data  <= mech_data_n;
      mech_latch <= (state_n == LATCH);
      mech_dst   <= (state_n == BURN);
    end
  end

endmodule

// File: tb/tb_print_mech_driver.sv
// Bench for print_mech_driver: directed scenarios plus random lines, checked by a receiving head model.
// Latency: expected line time computed from the parameter arithmetic.
// Backpressure: drives line_valid only when line_ready, except deliberate pokes during BURN.
module tb_print_mech_driver;
  localparam int HW = 8;
  localparam int CD = 2;
  localparam int LC = 3;
  localparam int BC = 4;
  localparam int SC = 5;
  localparam int LINE_CYCLES = 2 * CD * HW + LC + BC + 2 * SC;

  logic          clk = 1'b0;
  logic          reset;
  logic          line_valid;
  logic [HW-1:0] line_data;
  logic          line_ready, line_done, busy;
  logic          mech_clk, mech_data, mech_latch, mech_dst;
  logic          pa, pb;

  print_mech_driver #(
    .HEAD_WIDTH(HW), .CLK_DIV(CD), .LATCH_CYCLES(LC), .BURN_CYCLES(BC), .STEP_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .line_valid(line_valid), .line_data(line_data),
    .line_ready(line_ready), .line_done(line_done), .busy(busy),
    .mech_clk(mech_clk), .mech_data(mech_data), .mech_latch(mech_latch), .mech_dst(mech_dst),
    .mech_motor_phase_a(pa), .mech_motor_phase_b(pb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Receiving print mechanism model (written only by its own process).
  int          cyc = 0, rises = 0, latch_hi = 0, dst_hi = 0, ticks = 0, dones = 0, viol = 0, steps = 0;
  logic [63:0] bits = '0;
  logic [7:0]  print_line = '0;
  logic [1:0]  phase_q[$];
  int          phase_cyc_q[$];
  logic        prev_clk = 1'b0, prev_data = 1'b0, prev_latch = 1'b0;
  logic [1:0]  prev_ph = 2'b00;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mech_clk && !prev_clk) begin
        rises++;
        bits = {bits[62:0], mech_data};
      end
      if (prev_clk && mech_clk && (mech_data !== prev_data)) viol++;
      if (mech_latch && mech_dst) viol++;
      if ((mech_latch || mech_dst) && mech_clk) viol++;
      if (mech_latch) latch_hi++;
      if (mech_dst) dst_hi++;
      if (mech_latch && !prev_latch) begin
        print_line = bits[7:0];
        steps = 0;
      end
      if ({pa, pb} !== prev_ph) begin
        phase_q.push_back({pa, pb});
        phase_cyc_q.push_back(cyc);
        steps++;
        if (steps == 2) ticks++;
      end
      if (line_done) dones++;
      prev_clk   = mech_clk;
      prev_data  = mech_data;
      prev_latch = mech_latch;
      prev_ph    = {pa, pb};
    end
  end

  // Expected motor position as an index into the phase sequence.
  logic [1:0] ph_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int ph_idx = 0;
  int ph_rd = 0;
  int last_done = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_line(input logic [7:0] d, output int acc);
    int i;
    i = 0;
    while (line_ready !== 1'b1 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("ready_wait", line_ready, 1);
    line_valid = 1'b1;
    line_data  = d;
    @(negedge clk);
    acc = cyc;
    line_valid = 1'b0;
  endtask

  task automatic run_line(input logic [7:0] d, input bit poke, input bit b2b);
    int r0, l0, d0, t0, dn0, acc, dc, i;
    r0 = rises; l0 = latch_hi; d0 = dst_hi; t0 = ticks; dn0 = dones;
    send_line(d, acc);
    if (b2b) check("b2b_gap", acc - last_done, 1);
    check("busy_in_line", busy, 1);
    check("ready_in_line", line_ready, 0);
    if (poke) begin
      i = 0;
      while (mech_dst !== 1'b1 && i < 200) begin
        @(negedge clk);
        i++;
      end
      check("burn_reached", mech_dst, 1);
      check("ready_in_burn", line_ready, 0);
      line_valid = 1'b1;
      line_data  = 8'($urandom);
      @(negedge clk);
      line_valid = 1'b0;
    end
    i = 0;
    while (line_done !== 1'b1 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", line_done, 1);
    dc = cyc;
    last_done = dc;
    check("latency", dc - acc, LINE_CYCLES);
    check("rises", rises - r0, HW);
    check("print_line", print_line, d);
    check("latch_cycles", latch_hi - l0, LC);
    check("dst_cycles", dst_hi - d0, BC);
    check("advance_tick", ticks - t0, 1);
    check("done_pulses", dones - dn0, 1);
    check("done_ready", line_ready, 1);
    check("done_busy", busy, 0);
    check("done_mech_idle", {mech_clk, mech_data, mech_latch, mech_dst}, 0);
    check("phase_changes", phase_q.size() - ph_rd, 2);
    if (phase_q.size() >= ph_rd + 2) begin
      check("phase_step1", phase_q[ph_rd], ph_seq[(ph_idx + 1) % 4]);
      check("phase_step2", phase_q[ph_rd + 1], ph_seq[(ph_idx + 2) % 4]);
      check("phase_hold", phase_cyc_q[ph_rd + 1] - phase_cyc_q[ph_rd], SC);
    end
    ph_idx = (ph_idx + 2) % 4;
    ph_rd  = phase_q.size();
    check("phase_now", {pa, pb}, ph_seq[ph_idx]);
    if (poke) begin
      repeat (10) @(negedge clk);
      check("poke_no_restart", rises - r0, HW);
      check("poke_idle", busy, 0);
    end
  endtask

  initial begin
    int r0, dn0, l0, d0, acc, i, gap;
    bit poke, b2b_next;
    reset = 1'b1;
    line_valid = 1'b0;
    line_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", line_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", line_done, 0);
    check("rst_mech", {mech_clk, mech_data, mech_latch, mech_dst}, 0);
    check("rst_phase", {pa, pb}, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", line_ready, 1);

    // Directed lines: A5, then FF accepted on the line_done cycle, then a BURN poke.
    run_line(8'hA5, 1'b0, 1'b0);
    run_line(8'hFF, 1'b0, 1'b1);
    run_line(8'h5A, 1'b1, 1'b0);

    // Reset after three dots aborts the line silently.
    r0 = rises; dn0 = dones; l0 = latch_hi; d0 = dst_hi;
    send_line(8'hC3, acc);
    i = 0;
    while ((rises - r0) < 3 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("abort_3dots", rises - r0, 3);
    reset = 1'b1;
    @(negedge clk);
    check("abort_mech", {mech_clk, mech_data, mech_latch, mech_dst}, 0);
    check("abort_phase", {pa, pb}, 2'b00);
    check("abort_busy", busy, 0);
    check("abort_ready", line_ready, 0);
    reset = 1'b0;
    repeat (LINE_CYCLES + 10) @(negedge clk);
    check("abort_no_done", dones - dn0, 0);
    check("abort_no_latch", latch_hi - l0, 0);
    check("abort_no_dst", dst_hi - d0, 0);
    check("abort_no_dots", rises - r0, 3);
    ph_idx = 0;
    ph_rd  = phase_q.size();
    run_line(8'h3C, 1'b0, 1'b0);

    // Random lines with random gaps and random BURN pokes.
    b2b_next = 1'b0;
    for (int n = 0; n < 8; n++) begin
      poke = 1'($urandom_range(0, 1));
      gap  = $urandom_range(0, 2);
      run_line(8'($urandom), poke, b2b_next);
      if (gap > 0) repeat (gap) @(negedge clk);
      b2b_next = (gap == 0) && !poke;
    end

    check("protocol_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
